dsc_mul_seq: RTL and testbench
==============================

DSC_MUL_SEQ -- requirements
Module: dsc_mul_seq

Interface
REQ-001 Parameter NUM_BITS, default 8, SHALL set the operand width; four operands are fixed, and the result width is 4*NUM_BITS.
REQ-002 Parameter CYC_W, default 40, SHALL set the width of the cycle counter.
REQ-003 Parameter MAX_CYC, default 0, SHALL set the timeout limit in RUN cycles; 0 disables the timeout.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-low (rst=0 resets on the next clk edge).
REQ-006 Ports in_valid (input, 1) and in_ready (output, 1): operand handshake.
REQ-007 Ports in_a, in_b, in_c, in_d, input, NUM_BITS each: operands.
REQ-008 Ports mul_a, mul_b, mul_c, mul_d, output, NUM_BITS each: registered operands driven to the multiplier core.
REQ-009 Ports mul_rst (output, 1, active-high core reset) and mul_en (output, 1): core control.
REQ-010 Port mul_z, input, 4*NUM_BITS: core result.
REQ-011 Port mul_ov, input, 1: core done flag.
REQ-012 Ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-013 Port out_z, output, 4*NUM_BITS: result.
REQ-014 Port out_cycles, output, CYC_W: number of RUN cycles taken.
REQ-015 Port out_err, output, 1: timeout flag.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, RUN, SETTLE and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; an accept occurs when in_valid=1 and in_ready=1 at a clk edge.
REQ-018 On accept, in_a..in_d SHALL be registered into mul_a..mul_d, which then hold until the next accept.
REQ-019 On accept, if any operand is 0, the FSM SHALL go directly to DONE with out_z=0, out_cycles=0 and out_err=0 (zero shortcut); otherwise it SHALL go to LOAD.
REQ-020 LOAD SHALL last exactly 1 cycle, with mul_rst=1 and mul_en=0, and then go to RUN.
REQ-021 In RUN, mul_rst SHALL be 0, mul_en SHALL be 1, and the cycle counter SHALL increment by 1 each cycle, starting from 0 at LOAD.
REQ-022 In RUN, mul_ov=1 SHALL cause a transition to SETTLE.
REQ-023 In SETTLE (1 cycle), mul_en SHALL be 1 and mul_rst SHALL be 0; at the end of SETTLE, out_z SHALL capture mul_z, out_cycles SHALL capture the counter, out_err SHALL be set to 0, and the FSM SHALL go to DONE.
REQ-024 In RUN, if MAX_CYC≠0 and the counter reaches MAX_CYC without mul_ov, the FSM SHALL go to DONE with out_z=0, out_cycles=MAX_CYC and out_err=1.
REQ-025 If mul_ov and the timeout occur in the same cycle, mul_ov SHALL win.
REQ-026 The cycle counter SHALL saturate at its all-ones value and never wrap.
REQ-027 mul_rst SHALL be 1 in IDLE, LOAD and DONE, and 0 in RUN and SETTLE; mul_en SHALL be 1 only in RUN and SETTLE.
REQ-028 In DONE, out_valid SHALL be 1 and out_z, out_cycles and out_err SHALL stay stable until out_ready=1; then the FSM SHALL go to IDLE.
REQ-029 A new operand set SHALL be accepted no earlier than the cycle after the DONE→IDLE transition; there is no same-cycle bypass.
REQ-030 out_valid SHALL never be asserted in any state other than DONE.

Reset
REQ-031 With rst=0 at a clk edge, the state SHALL become IDLE from any state, including mid-RUN.
REQ-032 Reset SHALL clear mul_a..mul_d, out_z, out_cycles, out_err, out_valid, mul_en and the counter to 0, and SHALL set mul_rst=1.
REQ-033 in_ready SHALL be 0 while rst=0 and SHALL be 1 on the first cycle after reset is released.
REQ-034 A result in progress when reset is applied SHALL be discarded; out_valid SHALL not be asserted for it.

Verification
REQ-035 Nominal: a=b=c=d=15 with a real dsc_mul core → out_z=50625, out_err=0, and out_cycles equals the number of bench-counted mul_en=1 cycles in RUN.
REQ-036 Max operands: a=b=c=d=255 with a stub core asserting mul_ov after 10 RUN cycles and mul_z=4228250625 → out_z=4228250625 and out_cycles=10.
REQ-037 Zero shortcut: a=0, b=c=d=200 → out_valid=1 on the cycle after accept, out_z=0, out_cycles=0, and mul_en never asserted.
REQ-038 Timeout: MAX_CYC=16 with a stub core holding mul_ov=0 → out_err=1, out_z=0, out_cycles=16, and mul_rst returns to 1 in DONE.
REQ-039 Backpressure: out_ready=0 for 5 cycles in DONE → out_z, out_cycles and out_err stable, in_ready=0 throughout; out_ready=1 → IDLE on the next edge.
REQ-040 Reset mid-RUN: rst=0 for 1 cycle at RUN cycle 7 → IDLE, mul_rst=1, out_valid stays 0, in_ready=1 on the next cycle, and the following operation completes correctly.

Source files
------------

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: sequencer wrapping a 4-operand multiplier core with zero shortcut, cycle count and timeout
module dsc_mul_seq #(
  parameter int NUM_BITS = 8,
  parameter int CYC_W    = 40,
  parameter int MAX_CYC  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_BITS-1:0]   in_a,
  input  logic [NUM_BITS-1:0]   in_b,
  input  logic [NUM_BITS-1:0]   in_c,
  input  logic [NUM_BITS-1:0]   in_d,
  output logic [NUM_BITS-1:0]   mul_a,
  output logic [NUM_BITS-1:0]   mul_b,
  output logic [NUM_BITS-1:0]   mul_c,
  output logic [NUM_BITS-1:0]   mul_d,
  output logic                  mul_rst,
  output logic                  mul_en,
  input  logic [4*NUM_BITS-1:0] mul_z,
  input  logic                  mul_ov,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NUM_BITS-1:0] out_z,
  output logic [CYC_W-1:0]      out_cycles,
  output logic                  out_err
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, DONE} state_t;
  localparam logic [CYC_W-1:0] MAX_L = CYC_W'(MAX_CYC);
  state_t state_q, state_d;
  logic [NUM_BITS-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [4*NUM_BITS-1:0] z_q, z_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, cnt_q, cnt_d, cnt_inc;
  logic err_q, err_d;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    z_d = z_q;
    cyc_d = cyc_q;
    err_d = err_q;
    cnt_d = cnt_q;
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CYC_W'(1);
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = in_a;
        b_d = in_b;
        c_d = in_c;
        d_d = in_d;
        if (~|in_a || ~|in_b || ~|in_c || ~|in_d) begin
          z_d = '0;
          cyc_d = '0;
          err_d = 1'b0;
          state_d = DONE;
        end else state_d = LOAD;
      end
      LOAD: begin
        cnt_d = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (mul_ov) state_d = SETTLE;
        else if (MAX_CYC != 0 && cnt_inc == MAX_L) begin
          z_d = '0;
          cyc_d = MAX_L;
          err_d = 1'b1;
          state_d = DONE;
        end
      end
      SETTLE: begin
        z_d = mul_z;
        cyc_d = cnt_q;
        err_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      z_q <= '0;
      cyc_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      z_q <= z_d;
      cyc_q <= cyc_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready   = rst && state_q == IDLE;
  assign mul_en     = state_q == RUN || state_q == SETTLE;
  assign mul_rst    = !mul_en;
  assign out_valid  = state_q == DONE;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_c      = c_q;
  assign mul_d      = d_q;
  assign out_z      = z_q;
  assign out_cycles = cyc_q;
  assign out_err    = err_q;
endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: directed checks of dsc_mul_seq against a stub multiplier core
module tb_dsc_mul_seq;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_a = 0, in_b = 0, in_c = 0, in_d = 0, mul_a, mul_b, mul_c, mul_d;
  logic mul_rst, mul_en, mul_ov, out_valid, out_err, in_ready;
  logic [31:0] mul_z, out_z;
  logic [39:0] out_cycles;
  int checks = 0, errors = 0, ov_at = 0, en_cnt = 0, en_total = 0, e0;

  dsc_mul_seq #(.NUM_BITS(8), .CYC_W(40), .MAX_CYC(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_rst(mul_rst), .mul_en(mul_en), .mul_z(mul_z), .mul_ov(mul_ov),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_cycles(out_cycles), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // core stub: product of its operands, done flag raised in the ov_at-th enabled cycle
  assign mul_z  = {24'd0, mul_a} * {24'd0, mul_b} * {24'd0, mul_c} * {24'd0, mul_d};
  assign mul_ov = ov_at != 0 && en_cnt == ov_at - 1;
  always @(posedge clk) begin
    en_cnt <= mul_rst ? 0 : en_cnt + int'(mul_en);
    en_total <= en_total + int'(mul_en);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] a, b, c, d);
    in_a = a; in_b = b; in_c = c; in_d = d; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    chk("done_seen", out_valid, 1);
  endtask

  task automatic release_out();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_cycles", out_cycles, 0);
    chk("rst_out_err", out_err, 0);
    rst = 1;
    #1 chk("rel_rst_in_ready", in_ready, 1);
    @(negedge clk);
    // nominal 15^4
    ov_at = 7; e0 = en_total;
    start(15, 15, 15, 15);
    chk("nom_in_ready", in_ready, 0);
    chk("nom_mul_a", mul_a, 15);
    wait_done();
    chk("nom_z", out_z, 50625);
    chk("nom_cycles", out_cycles, 7);
    chk("nom_err", out_err, 0);
    chk("nom_en_cycles", en_total - e0, 8);
    release_out();
    // max operands with backpressure
    ov_at = 10;
    start(255, 255, 255, 255);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      chk("bp_z", out_z, 32'd4228250625);
      chk("bp_cycles", out_cycles, 10);
      chk("bp_err", out_err, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    release_out();
    // zero shortcut
    e0 = en_total;
    start(0, 200, 200, 200);
    chk("zero_valid", out_valid, 1);
    chk("zero_z", out_z, 0);
    chk("zero_cycles", out_cycles, 0);
    chk("zero_err", out_err, 0);
    chk("zero_mul_b", mul_b, 200);
    chk("zero_en", en_total - e0, 0);
    // no accept in the same cycle as DONE->IDLE
    ov_at = 3;
    in_a = 9; in_b = 9; in_c = 9; in_d = 9; in_valid = 1; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("nobypass_mul_a", mul_a, 0);
    chk("nobypass_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
    chk("accept_mul_a", mul_a, 9);
    wait_done();
    chk("nine_z", out_z, 6561);
    chk("nine_cycles", out_cycles, 3);
    release_out();
    // timeout
    ov_at = 0; e0 = en_total;
    start(5, 6, 7, 8);
    wait_done();
    chk("to_err", out_err, 1);
    chk("to_z", out_z, 0);
    chk("to_cycles", out_cycles, 16);
    chk("to_mul_rst", mul_rst, 1);
    chk("to_en_cycles", en_total - e0, 16);
    release_out();
    // done and timeout in the same cycle: done wins
    ov_at = 16;
    start(1, 2, 3, 4);
    wait_done();
    chk("tie_err", out_err, 0);
    chk("tie_z", out_z, 24);
    chk("tie_cycles", out_cycles, 16);
    release_out();
    // reset during RUN cycle 7
    ov_at = 12;
    start(3, 3, 3, 3);
    repeat (7) @(negedge clk);
    chk("mid_mul_en", mul_en, 1);
    rst = 0;
    @(negedge clk);
    chk("mid_mul_rst", mul_rst, 1);
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready_low", in_ready, 0);
    chk("mid_mul_a", mul_a, 0);
    rst = 1;
    #1 chk("mid_in_ready", in_ready, 1);
    repeat (20) @(negedge clk);
    chk("mid_no_valid", out_valid, 0);
    ov_at = 4;
    start(2, 3, 5, 7);
    wait_done();
    chk("post_z", out_z, 210);
    chk("post_cycles", out_cycles, 4);
    chk("post_err", out_err, 0);
    release_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
